// File: rtl/bmp280_seq.sv
// BMP280 SPI transaction sequencer: verifies the chip ID, writes config/ctrl_meas,
// then burst-reads the raw measurement block periodically and publishes it atomically.
module bmp280_seq #(
    parameter int unsigned CLK_IN    = 120000000,
    parameter int unsigned SAMPLE_HZ = 10,
    parameter logic [7:0]  CTRL_MEAS = 8'h27,
    parameter logic [7:0]  CONFIG    = 8'h00,
    parameter int unsigned CS_GAP    = 4
) (
    input  logic        clk_in,
    input  logic        n_rst,
    input  logic        enable,
    output logic        xfer_start,
    output logic [7:0]  xfer_tx,
    input  logic        xfer_busy,
    input  logic        xfer_done,
    input  logic [7:0]  xfer_rx,
    output logic        spi_cs_n,
    output logic        cfg_done,
    output logic        id_err,
    output logic        data_valid,
    output logic [19:0] press_raw,
    output logic [19:0] temp_raw
);

    localparam int unsigned PERIOD = CLK_IN / SAMPLE_HZ;
    localparam int unsigned TW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int unsigned GW     = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(PERIOD - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(CS_GAP - 1);
    // Hold starts the cycle after xfer_done, so one cycle is already spent.
    localparam logic [GW-1:0] HOLD_LOAD  = GW'(CS_GAP - 2);

    localparam logic [6:0] ADDR_ID   = 7'h50;
    localparam logic [6:0] ADDR_CFG  = 7'h75;
    localparam logic [6:0] ADDR_CTRL = 7'h74;
    localparam logic [6:0] ADDR_DATA = 7'h77;
    localparam logic [7:0] CHIP_ID   = 8'h58;

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_SETUP, S_START, S_BUSY, S_HOLD, S_ERR
    } state_t;

    typedef enum logic [1:0] {T_ID, T_CFG, T_CTRL, T_RD} txn_t;

    state_t        state_q, state_d;
    txn_t          txn_q, txn_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    idx_q, idx_d;
    logic          abort_q, abort_d;
    logic          id_ok_q, id_ok_d;
    logic [35:0]   raw_q, raw_d;
    logic          cs_n_q, cs_n_d;
    logic [7:0]    tx_q, tx_d;
    logic          cfg_done_q, cfg_done_d;
    logic          id_err_q, id_err_d;
    logic          valid_q, valid_d;
    logic [19:0]   press_q, press_d;
    logic [19:0]   temp_q, temp_d;
    logic [2:0]    last_idx;

    function automatic logic [7:0] tx_byte(input txn_t t, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 3'd0) begin
            case (t)
                T_ID:    b = {1'b1, ADDR_ID};
                T_CFG:   b = {1'b0, ADDR_CFG};
                T_CTRL:  b = {1'b0, ADDR_CTRL};
                default: b = {1'b1, ADDR_DATA};
            endcase
        end else begin
            case (t)
                T_CFG:   b = CONFIG;
                T_CTRL:  b = CTRL_MEAS;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign last_idx = (txn_q == T_RD) ? 3'd6 : 3'd1;

    always_comb begin
        state_d    = state_q;
        txn_d      = txn_q;
        cnt_d      = cnt_q;
        gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        timer_d    = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        idx_d      = idx_q;
        abort_d    = abort_q;
        id_ok_d    = id_ok_q;
        raw_d      = raw_q;
        cs_n_d     = cs_n_q;
        tx_d       = tx_q;
        cfg_done_d = cfg_done_q;
        id_err_d   = id_err_q;
        valid_d    = 1'b0;
        press_d    = press_q;
        temp_d     = temp_q;
        xfer_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                id_err_d   = 1'b0;
                cfg_done_d = 1'b0;
                if (enable) begin
                    txn_d   = T_ID;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (!enable) begin
                    cfg_done_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (gap_q == '0 && (txn_q != T_RD || timer_q == '0)) begin
                    cs_n_d  = 1'b0;
                    cnt_d   = GAP_LOAD;
                    idx_d   = 3'd0;
                    abort_d = 1'b0;
                    state_d = S_SETUP;
                    if (txn_q == T_RD) begin
                        timer_d = TIMER_LOAD;
                    end
                end
            end
            S_SETUP: begin
                if (!enable) begin
                    abort_d = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end else if (cnt_q == '0) begin
                    tx_d    = tx_byte(txn_q, idx_q);
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q - GW'(1);
                end
            end
            S_START: begin
                if (!enable) begin
                    abort_d = 1'b1;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end else if (!xfer_busy) begin
                    xfer_start = 1'b1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (xfer_done) begin
                    if (txn_q == T_ID && idx_q == 3'd1) begin
                        id_ok_d = (xfer_rx == CHIP_ID);
                    end
                    if (txn_q == T_RD) begin
                        case (idx_q)
                            3'd1:    raw_d[35:28] = xfer_rx;
                            3'd2:    raw_d[27:20] = xfer_rx;
                            3'd3:    raw_d[19:16] = xfer_rx[7:4];
                            3'd4:    raw_d[15:8]  = xfer_rx;
                            3'd5:    raw_d[7:0]   = xfer_rx;
                            default: ;
                        endcase
                    end
                    if (!enable || idx_q == last_idx) begin
                        abort_d = !enable;
                        cnt_d   = HOLD_LOAD;
                        state_d = S_HOLD;
                        // Last data byte is taken straight from xfer_rx so both words land together.
                        if (enable && txn_q == T_RD) begin
                            press_d = raw_q[35:16];
                            temp_d  = {raw_q[15:0], xfer_rx[7:4]};
                            valid_d = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_d    = tx_byte(txn_q, idx_q + 3'd1);
                        state_d = S_START;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - GW'(1);
                end else begin
                    cs_n_d = 1'b1;
                    gap_d  = GAP_LOAD;
                    if (abort_q || !enable) begin
                        cfg_done_d = 1'b0;
                        id_err_d   = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        case (txn_q)
                            T_ID: begin
                                if (id_ok_q) begin
                                    txn_d   = T_CFG;
                                    state_d = S_GAP;
                                end else begin
                                    id_err_d = 1'b1;
                                    state_d  = S_ERR;
                                end
                            end
                            T_CFG: begin
                                txn_d   = T_CTRL;
                                state_d = S_GAP;
                            end
                            T_CTRL: begin
                                cfg_done_d = 1'b1;
                                txn_d      = T_RD;
                                timer_d    = '0;
                                state_d    = S_GAP;
                            end
                            default: state_d = S_GAP;
                        endcase
                    end
                end
            end
            S_ERR: begin
                if (!enable) begin
                    id_err_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            txn_q      <= T_ID;
            cnt_q      <= '0;
            gap_q      <= GAP_LOAD;
            timer_q    <= '0;
            idx_q      <= 3'd0;
            abort_q    <= 1'b0;
            id_ok_q    <= 1'b0;
            raw_q      <= '0;
            cs_n_q     <= 1'b1;
            tx_q       <= 8'h00;
            cfg_done_q <= 1'b0;
            id_err_q   <= 1'b0;
            valid_q    <= 1'b0;
            press_q    <= '0;
            temp_q     <= '0;
        end else begin
            state_q    <= state_d;
            txn_q      <= txn_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            abort_q    <= abort_d;
            id_ok_q    <= id_ok_d;
            raw_q      <= raw_d;
            cs_n_q     <= cs_n_d;
            tx_q       <= tx_d;
            cfg_done_q <= cfg_done_d;
            id_err_q   <= id_err_d;
            valid_q    <= valid_d;
            press_q    <= press_d;
            temp_q     <= temp_d;
        end
    end

    assign spi_cs_n   = cs_n_q;
    assign xfer_tx    = tx_q;
    assign cfg_done   = cfg_done_q;
    assign id_err     = id_err_q;
    assign data_valid = valid_q;
    assign press_raw  = press_q;
    assign temp_raw   = temp_q;

endmodule

// File: tb/tb_bmp280_seq.sv
// Directed bench for bmp280_seq: byte-engine model with configurable latency,
// framing monitor, and hand-computed expectations for ID, config, burst, period, abort, reset.
module tb_bmp280_seq;

    logic        clk_in = 1'b0;
    logic        n_rst;
    logic        enable;
    logic        xfer_start;
    logic [7:0]  xfer_tx;
    logic        xfer_busy = 1'b0;
    logic        xfer_done = 1'b0;
    logic [7:0]  xfer_rx = 8'h00;
    logic        spi_cs_n;
    logic        cfg_done;
    logic        id_err;
    logic        data_valid;
    logic [19:0] press_raw;
    logic [19:0] temp_raw;

    always #5 clk_in = ~clk_in;

    bmp280_seq #(
        .CLK_IN(1000), .SAMPLE_HZ(10), .CTRL_MEAS(8'h27), .CONFIG(8'h00), .CS_GAP(4)
    ) dut (
        .clk_in(clk_in), .n_rst(n_rst), .enable(enable),
        .xfer_start(xfer_start), .xfer_tx(xfer_tx), .xfer_busy(xfer_busy),
        .xfer_done(xfer_done), .xfer_rx(xfer_rx), .spi_cs_n(spi_cs_n),
        .cfg_done(cfg_done), .id_err(id_err), .data_valid(data_valid),
        .press_raw(press_raw), .temp_raw(temp_raw)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // ---------------- byte engine model ----------------
    int         lat = 0;
    int         lat_cnt = 0;
    int         pos = 0;
    logic [7:0] first_tx = 8'h00;
    logic [7:0] cur_tx = 8'h00;
    logic [7:0] id_resp;
    logic [7:0] rd_bytes [6];
    logic [7:0] tx_log [$];

    function automatic logic [7:0] resp(input logic [7:0] first, input int p);
        if (first == 8'hD0 && p == 2) return id_resp;
        if (first == 8'hF7 && p >= 2 && p <= 7) return rd_bytes[p-2];
        return 8'hA5;
    endfunction

    always @(posedge clk_in) begin
        if (!n_rst) begin
            xfer_busy <= 1'b0;
            xfer_done <= 1'b0;
            pos       <= 0;
        end else begin
            xfer_done <= 1'b0;
            if (spi_cs_n) pos <= 0;
            if (xfer_busy) begin
                if (lat_cnt == 0) begin
                    xfer_busy <= 1'b0;
                    xfer_done <= 1'b1;
                    xfer_rx   <= resp(first_tx, pos);
                    $display("xfer tx=%02h rx=%02h", cur_tx, resp(first_tx, pos));
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end else if (xfer_start) begin
                xfer_busy <= 1'b1;
                lat_cnt   <= lat;
                cur_tx    <= xfer_tx;
                pos       <= pos + 1;
                if (pos == 0) first_tx <= xfer_tx;
                tx_log.push_back(xfer_tx);
            end
        end
    end

    // ---------------- framing monitor ----------------
    int         cyc = 0;
    int         fall_cyc [$];
    int         last_done = -1000;
    int         last_fall = -1000;
    int         hi_run = 0;
    int         last_hi_run = 0;
    int         starts = 0;
    int         txn_starts = 0;
    int         dv_cnt = 0;
    logic [19:0] dv_press = '0;
    logic [19:0] dv_temp = '0;
    logic        prev_cs = 1'b1;
    logic        prev_dv = 1'b0;
    logic        prev_rst_n = 1'b0;
    logic [19:0] prev_press = '0;
    logic [19:0] prev_temp = '0;

    always @(negedge clk_in) begin
        cyc++;
        if (n_rst && prev_rst_n) begin
            if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
                check_eq("cs_high_min", 32'(hi_run >= 4), 1);
                fall_cyc.push_back(cyc);
                last_fall   = cyc;
                last_hi_run = hi_run;
                txn_starts  = 0;
            end
            if (spi_cs_n === 1'b1 && prev_cs === 1'b0)
                check_eq("cs_hold", cyc - last_done, 4);
            if (xfer_start) begin
                starts++;
                txn_starts++;
                check_eq("start_cs_low", spi_cs_n, 0);
                check_eq("start_not_busy", xfer_busy, 0);
                if (txn_starts == 1) check_eq("cs_setup", cyc - last_fall, 4);
                else check_eq("byte_gap", cyc - last_done, 1);
            end
            if (xfer_busy) check_eq("tx_stable", xfer_tx, cur_tx);
            if (press_raw !== prev_press || temp_raw !== prev_temp)
                check_eq("pub_only_on_valid", data_valid, 1);
            if (data_valid) begin
                check_eq("dv_pulse", prev_dv, 0);
                dv_cnt++;
                dv_press = press_raw;
                dv_temp  = temp_raw;
            end
            if (xfer_done) last_done = cyc;
        end
        hi_run     = (spi_cs_n === 1'b1) ? hi_run + 1 : 0;
        prev_cs    = spi_cs_n;
        prev_dv    = data_valid;
        prev_rst_n = n_rst;
        prev_press = press_raw;
        prev_temp  = temp_raw;
    end

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_cs_n"}, spi_cs_n, 1);
        check_eq({pfx, "_start"}, xfer_start, 0);
        check_eq({pfx, "_tx"}, xfer_tx, 0);
        check_eq({pfx, "_dv"}, data_valid, 0);
        check_eq({pfx, "_cfg_done"}, cfg_done, 0);
        check_eq({pfx, "_id_err"}, id_err, 0);
        check_eq({pfx, "_press"}, press_raw, 0);
        check_eq({pfx, "_temp"}, temp_raw, 0);
    endtask

    logic [7:0] exp_cfg [6] = '{8'hD0, 8'h00, 8'h75, 8'h00, 8'h74, 8'h27};

    initial begin
        int s0, d0, f0, n, k, abort_cyc;
        n_rst    = 1'b0;
        enable   = 1'b0;
        id_resp  = 8'h58;
        rd_bytes = '{8'h65, 8'h5A, 8'hC0, 8'h7E, 8'hED, 8'h00};
        repeat (3) tick();
        check_reset_outputs("rst");
        n_rst = 1'b1;
        repeat (5) tick();
        check_eq("idle_cs_n", spi_cs_n, 1);
        check_eq("idle_no_start", starts, 0);

        // Wrong chip ID
        id_resp = 8'h60;
        tx_log.delete();
        enable = 1'b1;
        for (int i = 0; i < 200 && id_err !== 1'b1; i++) tick();
        check_eq("id_err_set", id_err, 1);
        s0 = starts;
        repeat (30) tick();
        check_eq("err_no_start", starts - s0, 0);
        check_eq("err_cs_high", spi_cs_n, 1);
        check_eq("err_log_len", tx_log.size(), 2);
        check_eq("err_tx0", log_at(0), 8'hD0);
        check_eq("err_tx1", log_at(1), 8'h00);
        enable = 1'b0;
        repeat (3) tick();
        check_eq("id_err_clr", id_err, 0);
        s0 = starts;
        repeat (20) tick();
        check_eq("idle_after_err", starts - s0, 0);

        // Good ID, configuration writes
        id_resp = 8'h58;
        tx_log.delete();
        f0 = fall_cyc.size();
        enable = 1'b1;
        for (int i = 0; i < 300 && cfg_done !== 1'b1; i++) tick();
        check_eq("cfg_done_set", cfg_done, 1);
        check_eq("cfg_log_len", tx_log.size(), 6);
        for (int i = 0; i < 6; i++) check_eq($sformatf("cfg_tx%0d", i), log_at(i), exp_cfg[i]);
        check_eq("cfg_txn_count", fall_cyc.size() - f0, 3);

        // First burst
        d0 = dv_cnt;
        for (int i = 0; i < 300 && dv_cnt == d0; i++) tick();
        check_eq("burst_dv_count", dv_cnt - d0, 1);
        check_eq("burst_press", dv_press, 20'h655AC);
        check_eq("burst_temp", dv_temp, 20'h7EED0);
        check_eq("burst_log_len", tx_log.size(), 13);
        check_eq("burst_tx_addr", log_at(6), 8'hF7);
        for (int i = 7; i < 13; i++) check_eq($sformatf("burst_tx%0d", i - 6), log_at(i), 8'h00);

        // Sampling period
        n = fall_cyc.size();
        for (int i = 0; i < 400 && fall_cyc.size() < n + 2; i++) tick();
        check_eq("period_falls", fall_cyc.size() - n, 2);
        if (fall_cyc.size() >= n + 2) begin
            check_eq("period_1", fall_cyc[n] - fall_cyc[n-1], 100);
            check_eq("period_2", fall_cyc[n+1] - fall_cyc[n], 100);
        end

        // Slow engine: burst longer than the period
        lat = 30;
        n = fall_cyc.size();
        for (int i = 0; i < 1000 && fall_cyc.size() < n + 1; i++) tick();
        check_eq("slow_fall_seen", fall_cyc.size() - n, 1);
        check_eq("slow_cs_gap", last_hi_run, 4);
        if (fall_cyc.size() >= n + 1)
            check_eq("slow_spacing_gt", 32'(fall_cyc[n] - fall_cyc[n-1] > 100), 1);
        d0 = dv_cnt;
        for (int i = 0; i < 1000 && dv_cnt == d0; i++) tick();
        check_eq("slow_dv", dv_cnt - d0, 1);
        check_eq("slow_press", dv_press, 20'h655AC);

        // Abort after the 3rd burst byte is issued
        rd_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        lat = 3;
        n = fall_cyc.size();
        for (int i = 0; i < 1000 && fall_cyc.size() == n; i++) tick();
        k = 0;
        for (int i = 0; i < 500 && k < 3; i++) begin
            tick();
            if (xfer_start) k++;
        end
        check_eq("abort_reach", k, 3);
        tick();
        enable    = 1'b0;
        abort_cyc = cyc;
        s0 = starts;
        d0 = dv_cnt;
        repeat (60) tick();
        check_eq("abort_no_start", starts - s0, 0);
        check_eq("abort_byte_done", 32'(last_done > abort_cyc), 1);
        check_eq("abort_no_dv", dv_cnt - d0, 0);
        check_eq("abort_press", press_raw, 20'h655AC);
        check_eq("abort_temp", temp_raw, 20'h7EED0);
        check_eq("abort_cs_high", spi_cs_n, 1);
        check_eq("abort_cfg_done", cfg_done, 0);

        // Reset in the middle of a burst
        lat = 0;
        enable = 1'b1;
        k = 0;
        for (int i = 0; i < 500 && k == 0; i++) begin
            tick();
            if (xfer_start && xfer_tx == 8'hF7) k = 1;
        end
        check_eq("rst_burst_reach", k, 1);
        repeat (2) tick();
        n_rst = 1'b0;
        tick();
        check_reset_outputs("midrst");
        n_rst = 1'b1;
        tx_log.delete();
        for (int i = 0; i < 100 && tx_log.size() == 0; i++) tick();
        check_eq("restart_tx0", log_at(0), 8'hD0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no completion expected finish before 50000 cycles");
        $fatal(1, "timeout");
    end

endmodule
